db_hash_engine: RTL and testbench

//  N-way set-associative key/value hash table on on-chip RAM; successor to the single-way db_cont path.

---
 rtl/db_hash_engine.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_db_hash_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_hash_engine.sv
// db_hash_engine: WAYS-way set-associative key/value table held in on-chip RAM.
// Executes LOOKUP / INSERT / DELETE requests, one at a time. Every request gets exactly one
// result strobe three cycles after it is accepted.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   in_valid/in_ready   request handshake (transfer on in_valid && in_ready)
//   in_op               1=LOOKUP 2=INSERT 3=DELETE, anything else is a bad op
//   in_hash             precomputed key hash; bucket = in_hash[IDX_BITS-1:0]
//   in_key, in_value    key, and the value used by INSERT
//   out_valid           one-cycle result strobe
//   out_flag            1=HIT 2=MISS 3=INSERTED 4=UPDATED 5=FULL 6=DELETED 7=EXPIRED F=BADOP
//   out_value           stored value on HIT, old value on UPDATED, removed value on DELETED, else 0
//   stat_entries        number of valid entries
//
// Build option: define DB_AGING_EN to add per-entry 16-bit timestamps and expiry
// (parameters TICK_DIV and EXPIRE_TICKS exist only in that build).
module db_hash_engine #(
    parameter int unsigned KEY_SIZE  = 96,
    parameter int unsigned VAL_SIZE  = 32,
    parameter int unsigned HASH_SIZE = 32,
    parameter int unsigned IDX_BITS  = 10,
    parameter int unsigned WAYS      = 4
`ifdef DB_AGING_EN
    ,
    parameter int unsigned TICK_DIV     = 1024,
    parameter int unsigned EXPIRE_TICKS = 100
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     in_op,
    input  logic [HASH_SIZE-1:0]           in_hash,
    input  logic [KEY_SIZE-1:0]            in_key,
    input  logic [VAL_SIZE-1:0]            in_value,
    output logic                           out_valid,
    output logic [3:0]                     out_flag,
    output logic [VAL_SIZE-1:0]            out_value,
    output logic [IDX_BITS+$clog2(WAYS):0] stat_entries
);

    localparam int unsigned DEPTH  = 1 << IDX_BITS;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned STAT_W = IDX_BITS + $clog2(WAYS) + 1;
    localparam logic [STAT_W-1:0] StatMax = STAT_W'(WAYS * DEPTH);

    localparam logic [3:0] OpLookup = 4'h1, OpInsert = 4'h2, OpDelete = 4'h3;
    localparam logic [3:0] FlagHit = 4'h1, FlagMiss = 4'h2, FlagInserted = 4'h3;
    localparam logic [3:0] FlagUpdated = 4'h4, FlagFull = 4'h5, FlagDeleted = 4'h6;
    localparam logic [3:0] FlagExpired = 4'h7, FlagBadOp = 4'hF;

    typedef enum logic [2:0] {StInit, StIdle, StRd, StCmp, StResp} state_e;

    state_e                state_q;
    logic [IDX_BITS-1:0]   init_idx_q, idx_q;
    logic [3:0]            op_q;
    logic [KEY_SIZE-1:0]   key_q;
    logic [VAL_SIZE-1:0]   val_q;
    logic                  in_ready_q, out_valid_q;
    logic [3:0]            out_flag_q;
    logic [VAL_SIZE-1:0]   out_value_q;
    logic [STAT_W-1:0]     stat_q;

    // Table storage; only the valid bits need clearing at start-up.
    logic [WAYS-1:0]       valid_mem [DEPTH];
    logic [KEY_SIZE-1:0]   key_mem   [DEPTH][WAYS];
    logic [VAL_SIZE-1:0]   val_mem   [DEPTH][WAYS];

    // Bucket snapshot taken in RD, compare results taken in CMP.
    logic [WAYS-1:0]       rd_valid_q;
    logic [KEY_SIZE-1:0]   rd_key_q [WAYS];
    logic [VAL_SIZE-1:0]   rd_val_q [WAYS];
    logic                  hit_d, hit_q, hit_exp_d, hit_exp_q, free_d, free_q, free_exp_d, free_exp_q;
    logic [WAY_W-1:0]      hit_way_d, hit_way_q, free_way_d, free_way_q;
    logic [VAL_SIZE-1:0]   hit_val_d, hit_val_q;
    logic [WAYS-1:0]       expired;

    logic                  wr_en, clr_en, stat_inc, stat_dec;
    logic [WAY_W-1:0]      acc_way;
    logic [3:0]            resp_flag;
    logic [VAL_SIZE-1:0]   resp_val;

    // Only the bucket-index bits of the hash are used.
    logic unused_hash;
    assign unused_hash = ^in_hash[HASH_SIZE-1:IDX_BITS];

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_flag     = out_flag_q;
    assign out_value    = out_value_q;
    assign stat_entries = stat_q;

`ifdef DB_AGING_EN
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [DIV_W-1:0]      div_q;
    logic [15:0]           now_q;
    logic [15:0]           ts_mem  [DEPTH][WAYS];
    logic [15:0]           rd_ts_q [WAYS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            now_q <= '0;
        end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_q <= '0;
            now_q <= now_q + 16'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Age is taken modulo 2^16 so the tick counter may wrap freely.
    always_comb begin
        expired = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            expired[w] = rd_valid_q[w] && (16'(now_q - rd_ts_q[w]) > 16'(EXPIRE_TICKS));
        end
    end
`else
    assign expired = '0;
`endif

    // Lowest way wins: scan from the top so lower ways overwrite.
    always_comb begin
        hit_d      = 1'b0;
        hit_exp_d  = 1'b0;
        hit_way_d  = '0;
        hit_val_d  = '0;
        free_d     = 1'b0;
        free_exp_d = 1'b0;
        free_way_d = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (rd_valid_q[w] && (rd_key_q[w] == key_q)) begin
                hit_d     = 1'b1;
                hit_exp_d = expired[w];
                hit_way_d = WAY_W'(w);
                hit_val_d = rd_val_q[w];
            end
            if (!rd_valid_q[w] || expired[w]) begin
                free_d     = 1'b1;
                free_exp_d = rd_valid_q[w];
                free_way_d = WAY_W'(w);
            end
        end
    end

    // Result and table update for the op in RESP.
    always_comb begin
        resp_flag = FlagBadOp;
        resp_val  = '0;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        stat_inc  = 1'b0;
        stat_dec  = 1'b0;
        acc_way   = hit_way_q;
        case (op_q)
            OpLookup: begin
                if (!hit_q) begin
                    resp_flag = FlagMiss;
                end else if (hit_exp_q) begin
                    resp_flag = FlagExpired;
                    clr_en    = 1'b1;
                    stat_dec  = 1'b1;
                end else begin
                    resp_flag = FlagHit;
                    resp_val  = hit_val_q;
                end
            end
            OpInsert: begin
                if (hit_q) begin
                    // An expired match is replaced in place; it is already counted.
                    wr_en     = 1'b1;
                    resp_flag = hit_exp_q ? FlagInserted : FlagUpdated;
                    resp_val  = hit_exp_q ? '0 : hit_val_q;
                end else if (free_q) begin
                    wr_en     = 1'b1;
                    acc_way   = free_way_q;
                    resp_flag = FlagInserted;
                    stat_inc  = !free_exp_q;
                end else begin
                    resp_flag = FlagFull;
                end
            end
            OpDelete: begin
                if (!hit_q) begin
                    resp_flag = FlagMiss;
                end else begin
                    resp_flag = hit_exp_q ? FlagExpired : FlagDeleted;
                    resp_val  = hit_exp_q ? '0 : hit_val_q;
                    clr_en    = 1'b1;
                    stat_dec  = 1'b1;
                end
            end
            default: resp_flag = FlagBadOp;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInit;
            init_idx_q  <= '0;
            idx_q       <= '0;
            op_q        <= '0;
            key_q       <= '0;
            val_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= '0;
            out_value_q <= '0;
            stat_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == IDX_BITS'(DEPTH - 1)) begin
                        state_q    <= StIdle;
                        in_ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        idx_q      <= in_hash[IDX_BITS-1:0];
                        key_q      <= in_key;
                        val_q      <= in_value;
                        in_ready_q <= 1'b0;
                        state_q    <= StRd;
                    end
                end
                StRd:  state_q <= StCmp;
                StCmp: state_q <= StResp;
                StResp: begin
                    out_valid_q <= 1'b1;
                    out_flag_q  <= resp_flag;
                    out_value_q <= resp_val;
                    if (stat_inc && (stat_q != StatMax)) begin
                        stat_q <= stat_q + 1'b1;
                    end else if (stat_dec && (stat_q != '0)) begin
                        stat_q <= stat_q - 1'b1;
                    end
                    in_ready_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // RAM port plus pipeline data registers (no reset needed).
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            valid_mem[init_idx_q] <= '0;
        end else if (state_q == StResp) begin
            if (wr_en) begin
                valid_mem[idx_q][acc_way] <= 1'b1;
                key_mem[idx_q][acc_way]   <= key_q;
                val_mem[idx_q][acc_way]   <= val_q;
`ifdef DB_AGING_EN
                ts_mem[idx_q][acc_way]    <= now_q;
`endif
            end else if (clr_en) begin
                valid_mem[idx_q][acc_way] <= 1'b0;
            end
        end
        if (state_q == StRd) begin
            rd_valid_q <= valid_mem[idx_q];
            for (int w = 0; w < int'(WAYS); w++) begin
                rd_key_q[w] <= key_mem[idx_q][w];
                rd_val_q[w] <= val_mem[idx_q][w];
`ifdef DB_AGING_EN
                rd_ts_q[w]  <= ts_mem[idx_q][w];
`endif
            end
        end
        if (state_q == StCmp) begin
            hit_q      <= hit_d;
            hit_exp_q  <= hit_exp_d;
            hit_way_q  <= hit_way_d;
            hit_val_q  <= hit_val_d;
            free_q     <= free_d;
            free_exp_q <= free_exp_d;
            free_way_q <= free_way_d;
        end
    end

endmodule

// File: tb/tb_db_hash_engine.sv
// Self-checking bench for db_hash_engine: directed scenarios followed by random ops,
// all compared against a behavioural table model kept here.
module tb_db_hash_engine;

    localparam int unsigned KEY_SIZE  = 96;
    localparam int unsigned VAL_SIZE  = 32;
    localparam int unsigned HASH_SIZE = 32;
    localparam int unsigned IDX_BITS  = 10;
    localparam int unsigned WAYS      = 4;
    localparam int unsigned DEPTH     = 1 << IDX_BITS;
    localparam int unsigned STAT_W    = IDX_BITS + $clog2(WAYS) + 1;
`ifdef DB_AGING_EN
    localparam int unsigned TICK_DIV     = 4;
    localparam int unsigned EXPIRE_TICKS = 2;
`endif

    localparam logic [3:0] OP_LOOKUP = 4'h1, OP_INSERT = 4'h2, OP_DELETE = 4'h3;
    localparam logic [3:0] F_HIT = 4'h1, F_MISS = 4'h2, F_INSERTED = 4'h3, F_UPDATED = 4'h4;
    localparam logic [3:0] F_FULL = 4'h5, F_DELETED = 4'h6, F_EXPIRED = 4'h7, F_BADOP = 4'hF;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [3:0]           in_op = '0;
    logic [HASH_SIZE-1:0] in_hash = '0;
    logic [KEY_SIZE-1:0]  in_key = '0;
    logic [VAL_SIZE-1:0]  in_value = '0;
    logic                 out_valid;
    logic [3:0]           out_flag;
    logic [VAL_SIZE-1:0]  out_value;
    logic [STAT_W-1:0]    stat_entries;

    db_hash_engine #(
        .KEY_SIZE    (KEY_SIZE),
        .VAL_SIZE    (VAL_SIZE),
        .HASH_SIZE   (HASH_SIZE),
        .IDX_BITS    (IDX_BITS),
        .WAYS        (WAYS)
`ifdef DB_AGING_EN
        ,
        .TICK_DIV    (TICK_DIV),
        .EXPIRE_TICKS(EXPIRE_TICKS)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_hash     (in_hash),
        .in_key      (in_key),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_flag    (out_flag),
        .out_value   (out_value),
        .stat_entries(stat_entries)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the aging tick is this count divided by TICK_DIV.
    int unsigned cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Reference table.
    bit                  m_valid [DEPTH][WAYS];
    logic [KEY_SIZE-1:0] m_key   [DEPTH][WAYS];
    logic [VAL_SIZE-1:0] m_val   [DEPTH][WAYS];
    int unsigned         m_ts    [DEPTH][WAYS];
    int unsigned         m_stat;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int b = 0; b < int'(DEPTH); b++)
            for (int w = 0; w < int'(WAYS); w++) m_valid[b][w] = 1'b0;
        m_stat = 0;
    endfunction

    // t = edge count at acceptance; the compare sees tick (t+1)/TICK_DIV,
    // a written entry is stamped with tick (t+2)/TICK_DIV.
    function automatic void model_op(input logic [3:0] op, input logic [HASH_SIZE-1:0] h,
                                     input logic [KEY_SIZE-1:0] k, input logic [VAL_SIZE-1:0] v,
                                     input int unsigned t, output logic [3:0] flag,
                                     output logic [VAL_SIZE-1:0] val);
        int          b = int'(h[IDX_BITS-1:0]);
        int          hit = -1;
        int          fre = -1;
        bit          old [WAYS];
        int unsigned now_cmp = 0;
        int unsigned now_wr = 0;
`ifdef DB_AGING_EN
        now_cmp = ((t + 1) / TICK_DIV) % 65536;
        now_wr  = ((t + 2) / TICK_DIV) % 65536;
`else
        if (t == 0) now_wr = 0;
`endif
        for (int w = 0; w < int'(WAYS); w++) begin
            old[w] = 1'b0;
`ifdef DB_AGING_EN
            old[w] = m_valid[b][w] && (((now_cmp + 65536 - m_ts[b][w]) % 65536) > EXPIRE_TICKS);
`endif
        end
        for (int w = 0; w < int'(WAYS); w++) begin
            if (hit < 0 && m_valid[b][w] && m_key[b][w] == k) hit = w;
            if (fre < 0 && (!m_valid[b][w] || old[w])) fre = w;
        end
        flag = F_BADOP;
        val  = '0;
        case (op)
            OP_LOOKUP: begin
                if (hit < 0) flag = F_MISS;
                else if (old[hit]) begin
                    flag = F_EXPIRED;
                    m_valid[b][hit] = 1'b0;
                    m_stat--;
                end else begin
                    flag = F_HIT;
                    val  = m_val[b][hit];
                end
            end
            OP_INSERT: begin
                if (hit >= 0) begin
                    if (old[hit]) flag = F_INSERTED;
                    else begin
                        flag = F_UPDATED;
                        val  = m_val[b][hit];
                    end
                    m_val[b][hit] = v;
                    m_ts[b][hit]  = now_wr;
                end else if (fre >= 0) begin
                    if (!m_valid[b][fre]) m_stat++;
                    m_valid[b][fre] = 1'b1;
                    m_key[b][fre]   = k;
                    m_val[b][fre]   = v;
                    m_ts[b][fre]    = now_wr;
                    flag = F_INSERTED;
                end else begin
                    flag = F_FULL;
                end
            end
            OP_DELETE: begin
                if (hit < 0) flag = F_MISS;
                else begin
                    if (old[hit]) flag = F_EXPIRED;
                    else begin
                        flag = F_DELETED;
                        val  = m_val[b][hit];
                    end
                    m_valid[b][hit] = 1'b0;
                    m_stat--;
                end
            end
            default: flag = F_BADOP;
        endcase
    endfunction

    // Holds reset, checks reset values, releases it and checks the INIT walk length.
    task automatic do_reset();
        int hi = 0;
        int ov = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) ov++;
        end
        check("rst_in_ready", in_ready, 0);
        check("rst_out_flag", out_flag, 0);
        check("rst_out_value", out_value, 0);
        check("rst_stat", stat_entries, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e < int'(DEPTH); e++) begin
            @(posedge clk); #1;
            if (in_ready) hi++;
            if (out_valid) ov++;
        end
        check("init_ready_low", hi, 0);
        check("init_no_out_valid", ov, 0);
        @(posedge clk); #1;
        check("init_ready_high", in_ready, 1);
        check("init_stat", stat_entries, 0);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [HASH_SIZE-1:0] h,
                         input logic [KEY_SIZE-1:0] k, input logic [VAL_SIZE-1:0] v,
                         input string tag, output logic [3:0] flag_o,
                         output logic [VAL_SIZE-1:0] val_o);
        logic [3:0]          ef;
        logic [VAL_SIZE-1:0] ev;
        int unsigned         t;
        int                  n = 0;
        int                  w = 0;
        while (!in_ready && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_hash  = h;
        in_key   = k;
        in_value = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = $urandom();
        t = cyc;
        model_op(op, h, k, v, t, ef, ev);
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_flag"}, out_flag, ef);
        check({tag, "_value"}, out_value, ev);
        check({tag, "_stat"}, stat_entries, m_stat);
        flag_o = out_flag;
        val_o  = out_value;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [KEY_SIZE-1:0]  k1, k2, kk;
    logic [HASH_SIZE-1:0] h1;
    logic [3:0]           f;
    logic [VAL_SIZE-1:0]  v;
    logic [KEY_SIZE-1:0]  key_pool [15];
    logic [HASH_SIZE-1:0] hash_pool [15];

    initial begin
        k1 = {32'h0A00_0001, 32'h0A00_0002, 32'h1234_0000};
        k2 = {32'h0A00_0003, 32'h0A00_0002, 32'h1234_0000};
        h1 = 32'hABCD_0123;
        for (int i = 0; i < 15; i++) begin
            key_pool[i]  = {$urandom(), $urandom(), $urandom()};
            hash_pool[i] = ($urandom() & ~32'h3FF) | (32'h20 + 32'(i % 3));
        end

        // 1: reset and INIT
        do_reset();

        // 2: insert / lookup hit / lookup miss
        do_op(OP_INSERT, h1, k1, 32'hDEADBEEF, "t2_ins", f, v);
        check("t2_ins_const", f, F_INSERTED);
        do_op(OP_LOOKUP, h1, k1, 32'h0, "t2_hit", f, v);
        check("t2_hit_const", {f, v}, {F_HIT, 32'hDEADBEEF});
        do_op(OP_LOOKUP, h1, k2, 32'h0, "t2_miss", f, v);
        check("t2_miss_const", {f, v}, {F_MISS, 32'h0});

        // 3: WAYS+1 keys into bucket 5
        for (int i = 0; i <= int'(WAYS); i++) begin
            kk = {32'hC0A8_0000 + 32'(i), $urandom(), 32'h0000_0035};
            do_op(OP_INSERT, 32'h5, kk, $urandom(), "t3_ins", f, v);
        end

        // 4: update, delete, delete again
        do_op(OP_INSERT, h1, k1, 32'd7, "t4_ins7", f, v);
        do_op(OP_INSERT, h1, k1, 32'd9, "t4_ins9", f, v);
        check("t4_upd_const", {f, v}, {F_UPDATED, 32'd7});
        do_op(OP_DELETE, h1, k1, 32'h0, "t4_del", f, v);
        check("t4_del_const", {f, v}, {F_DELETED, 32'd9});
        do_op(OP_DELETE, h1, k1, 32'h0, "t4_del2", f, v);
        check("t4_del2_const", f, F_MISS);

        // 5: bad op, then reset while an op sits in CMP
        do_op(4'hA, h1, k1, 32'h1, "t5_bad", f, v);
        check("t5_bad_const", f, F_BADOP);
        do_op(OP_INSERT, h1, k2, 32'h55, "t5_pre", f, v);
        in_valid = 1'b1;
        in_op    = OP_LOOKUP;
        in_hash  = h1;
        in_key   = k2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5_abort_out_valid", out_valid, 0);
        check("t5_abort_stat", stat_entries, 0);
        do_reset();

`ifdef DB_AGING_EN
        // 6: entry ages out
        do_op(OP_INSERT, h1, k1, 32'h77, "t6_ins", f, v);
        repeat (16) @(posedge clk);
        #1;
        do_op(OP_LOOKUP, h1, k1, 32'h0, "t6_exp", f, v);
        check("t6_exp_const", f, F_EXPIRED);
        do_op(OP_LOOKUP, h1, k1, 32'h0, "t6_gone", f, v);
        check("t6_gone_const", f, F_MISS);
`endif

        // Random ops over a small key pool spread across three buckets
        for (int i = 0; i < 300; i++) begin
            int          r   = int'($urandom_range(0, 9));
            int          idx = int'($urandom_range(0, 14));
            logic [3:0]  op;
            if (r < 4)      op = OP_LOOKUP;
            else if (r < 7) op = OP_INSERT;
            else if (r < 9) op = OP_DELETE;
            else            op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(4, 15));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            do_op(op, hash_pool[idx], key_pool[idx], $urandom(), "rnd", f, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
